// File: rtl/wb_commit_pkg.sv
// Shared types for the RV32I writeback/commit slice: MEM/WB register layout,
// writeback mux select, commit FSM state and registered commit bundle.
// Latency: n/a (types only). Backpressure: n/a.
package rv32i_types;

  localparam int P_PHYS_W  = 6;
  localparam int P_ORDER_W = 64;

  // Load funct3 encodings (inst[14:12])
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [2:0] {
    RF_ALU  = 3'd0,
    RF_BR   = 3'd1,
    RF_UIMM = 3'd2,
    RF_PC4  = 3'd3,
    RF_LOAD = 3'd4
  } regfilemux_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [31:0]           inst;
    logic [31:0]           pc;
    logic [3:0]            dmem_rmask;
    logic [3:0]            dmem_wmask;
    logic [31:0]           dmem_addr;
    regfilemux_sel_t       regfilemux_sel;
    logic [31:0]           alu_out;
    logic                  br_en;
    logic [31:0]           u_imm;
    logic                  regf_we;
    logic [4:0]            dest_arch;
    logic [P_PHYS_W-1:0]   dest_phys_new;
    logic [P_PHYS_W-1:0]   dest_phys_old;
  } mem_wb_stage_reg_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic                  we;
    logic [P_PHYS_W-1:0]   phys;
    logic [31:0]           data;
    logic                  free;
    logic [4:0]            arch;
    logic [31:0]           pc;
    logic [P_ORDER_W-1:0]  order;
  } wb_commit_t;

endpackage

// File: rtl/wb_commit_load_align.sv
// Load data aligner: shifts the word-aligned read data down to the addressed
// byte and sign/zero-extends according to funct3.
// Latency: combinational. Backpressure: none.
// Ports: rdata (32b memory word), addr (byte offset), funct3, data_out (extended value).
module load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data_out
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata >> {addr, 3'b000};

  always_comb begin
    data_out = w_shifted;
    unique case (funct3)
      F3_LB:   data_out = {{24{w_shifted[7]}},  w_shifted[7:0]};
      F3_LH:   data_out = {{16{w_shifted[15]}}, w_shifted[15:0]};
      F3_LBU:  data_out = {24'h0, w_shifted[7:0]};
      F3_LHU:  data_out = {16'h0, w_shifted[15:0]};
      F3_LW:   data_out = w_shifted;
      default: data_out = w_shifted;
    endcase
  end

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: waits on data-memory responses, aligns load data,
// selects the writeback value and registers one commit (regfile write + free).
// Latency: commit outputs appear 1 cycle after the commit cycle.
// Backpressure: freeze_stall (combinational) holds the pipeline while a memory
// access is outstanding.
// Ports: clk/rst_n (async active-low); mem_wb_now, dmem_rdata, dmem_resp in;
// freeze_stall, rd_we/rd_phys/rd_data, free_valid/free_phys, commit_valid/
// commit_arch/commit_pc/commit_order, proto_err out.
// Optional macro WB_PERF_COUNTERS_EN adds perf_retired and perf_mem_stall.
module wb_commit
  import rv32i_types::*;
#(
  parameter int PHYS_W  = P_PHYS_W,
  parameter int ORDER_W = P_ORDER_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  mem_wb_stage_reg_t     mem_wb_now,
  input  logic [31:0]           dmem_rdata,
  input  logic                  dmem_resp,
  output logic                  freeze_stall,
  output logic                  rd_we,
  output logic [PHYS_W-1:0]     rd_phys,
  output logic [31:0]           rd_data,
  output logic                  free_valid,
  output logic [PHYS_W-1:0]     free_phys,
  output logic                  commit_valid,
  output logic [4:0]            commit_arch,
  output logic [31:0]           commit_pc,
  output logic [ORDER_W-1:0]    commit_order,
  output logic                  proto_err
`ifdef WB_PERF_COUNTERS_EN
  ,
  output logic [63:0]           perf_retired,
  output logic [63:0]           perf_mem_stall
`endif
);

  wb_state_t          r_state;
  wb_state_t          w_state_nxt;
  logic               w_mem_op;
  logic               w_commit;
  logic               w_stray_resp;
  logic               w_writes_reg;
  logic [31:0]        w_load_data;
  logic [31:0]        w_wb_data;
  logic               r_commit_vld;
  wb_commit_t         r_out;
  logic [ORDER_W-1:0] r_order;
  logic               r_proto_err;
  logic               w_unused_bits;

  assign w_mem_op = mem_wb_now.valid &&
                    ((mem_wb_now.dmem_rmask != 4'h0) || (mem_wb_now.dmem_wmask != 4'h0));

  // Register writes to x0 are architecturally discarded, so no mapping is freed.
  assign w_writes_reg = mem_wb_now.regf_we && (mem_wb_now.dest_arch != 5'd0);

  // Fields of the MEM/WB register this stage does not consume.
  assign w_unused_bits = ^{mem_wb_now.inst[31:15], mem_wb_now.inst[11:0],
                           mem_wb_now.dmem_addr[31:2]};

  load_align u_load_align (
    .rdata    (dmem_rdata),
    .addr     (mem_wb_now.dmem_addr[1:0]),
    .funct3   (mem_wb_now.inst[14:12]),
    .data_out (w_load_data)
  );

  always_comb begin
    w_wb_data = mem_wb_now.alu_out;
    unique case (mem_wb_now.regfilemux_sel)
      RF_ALU:  w_wb_data = mem_wb_now.alu_out;
      RF_BR:   w_wb_data = {31'h0, mem_wb_now.br_en};
      RF_UIMM: w_wb_data = mem_wb_now.u_imm;
      RF_PC4:  w_wb_data = mem_wb_now.pc + 32'd4;
      RF_LOAD: w_wb_data = w_load_data;
      default: w_wb_data = mem_wb_now.alu_out;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_mem_op && !dmem_resp) w_state_nxt = WAIT;
      WAIT:    if (dmem_resp)              w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM: outputs. The commit condition is the same in both states: a
  // non-memory instruction, or a memory op whose response is present.
  always_comb begin
    freeze_stall = w_mem_op && !dmem_resp;
    w_commit     = mem_wb_now.valid && (!w_mem_op || dmem_resp);
    w_stray_resp = (r_state == IDLE) && dmem_resp && !w_mem_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_commit_vld <= 1'b0;
      r_out        <= '0;
      r_order      <= '0;
      r_proto_err  <= 1'b0;
    end else begin
      r_commit_vld <= w_commit;
      if (w_commit) begin
        r_out.we    <= w_writes_reg;
        r_out.free  <= w_writes_reg;
        r_out.phys  <= mem_wb_now.dest_phys_new;
        r_out.data  <= w_wb_data;
        r_out.arch  <= mem_wb_now.dest_arch;
        r_out.pc    <= mem_wb_now.pc;
        r_out.order <= r_order;
        r_order     <= r_order + 1'b1;
      end else begin
        r_out <= '0;
      end
      if (w_stray_resp) begin
        r_proto_err <= 1'b1;
      end
    end
  end

  // free_phys is carried alongside the commit so it lines up with free_valid.
  logic [PHYS_W-1:0] r_free_phys;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_free_phys <= '0;
    end else if (w_commit) begin
      r_free_phys <= mem_wb_now.dest_phys_old;
    end else begin
      r_free_phys <= '0;
    end
  end

  assign rd_we        = r_out.we;
  assign rd_phys      = r_out.phys;
  assign rd_data      = r_out.data;
  assign free_valid   = r_out.free;
  assign free_phys    = r_free_phys;
  assign commit_valid = r_commit_vld;
  assign commit_arch  = r_out.arch;
  assign commit_pc    = r_out.pc;
  assign commit_order = r_out.order;
  assign proto_err    = r_proto_err;

`ifdef WB_PERF_COUNTERS_EN
  logic [63:0] r_perf_retired;
  logic [63:0] r_perf_mem_stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_retired   <= '0;
      r_perf_mem_stall <= '0;
    end else begin
      if (w_commit)     r_perf_retired   <= r_perf_retired + 64'd1;
      if (freeze_stall) r_perf_mem_stall <= r_perf_mem_stall + 64'd1;
    end
  end

  assign perf_retired   = r_perf_retired;
  assign perf_mem_stall = r_perf_mem_stall;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: table of single-cycle commits plus hand-written
// wait-state, stray-response and reset-in-WAIT sequences.
module tb_wb_commit;
  import rv32i_types::*;

  logic              clk;
  logic              rst_n;
  mem_wb_stage_reg_t mem_wb_now;
  logic [31:0]       dmem_rdata;
  logic              dmem_resp;
  logic              freeze_stall;
  logic              rd_we;
  logic [5:0]        rd_phys;
  logic [31:0]       rd_data;
  logic              free_valid;
  logic [5:0]        free_phys;
  logic              commit_valid;
  logic [4:0]        commit_arch;
  logic [31:0]       commit_pc;
  logic [63:0]       commit_order;
  logic              proto_err;
`ifdef WB_PERF_COUNTERS_EN
  logic [63:0]       perf_retired;
  logic [63:0]       perf_mem_stall;
`endif

  wb_commit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_wb_now   (mem_wb_now),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .freeze_stall (freeze_stall),
    .rd_we        (rd_we),
    .rd_phys      (rd_phys),
    .rd_data      (rd_data),
    .free_valid   (free_valid),
    .free_phys    (free_phys),
    .commit_valid (commit_valid),
    .commit_arch  (commit_arch),
    .commit_pc    (commit_pc),
    .commit_order (commit_order),
    .proto_err    (proto_err)
`ifdef WB_PERF_COUNTERS_EN
    ,
    .perf_retired   (perf_retired),
    .perf_mem_stall (perf_mem_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_order = 64'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic mem_wb_stage_reg_t mk(
    input logic [31:0] pc, input logic [2:0] f3,
    input logic [3:0] rmask, input logic [3:0] wmask, input logic [31:0] addr,
    input regfilemux_sel_t sel, input logic [31:0] alu, input logic br,
    input logic [31:0] uimm, input logic we, input logic [4:0] arch,
    input logic [5:0] pn, input logic [5:0] po);
    mem_wb_stage_reg_t m;
    m = '0;
    m.valid          = 1'b1;
    m.inst           = {17'h0, f3, 12'h003};
    m.pc             = pc;
    m.dmem_rmask     = rmask;
    m.dmem_wmask     = wmask;
    m.dmem_addr      = addr;
    m.regfilemux_sel = sel;
    m.alu_out        = alu;
    m.br_en          = br;
    m.u_imm          = uimm;
    m.regf_we        = we;
    m.dest_arch      = arch;
    m.dest_phys_new  = pn;
    m.dest_phys_old  = po;
    return m;
  endfunction

  typedef struct {
    string             name;
    mem_wb_stage_reg_t mw;
    logic [31:0]       rdata;
    logic              resp;
    logic              e_commit;
    logic              e_we;
    logic [31:0]       e_data;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs [NV];

  initial begin
    // Table: each entry is presented for one cycle and committed back-to-back.
    vecs[0]  = '{"lb_a2",   mk(32'h1000_0000, 3'b000, 4'b0100, 4'h0, 32'h0000_0102, RF_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 5'd5, 6'd7, 6'd3),
                 32'h80FF_7F00, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF};
    vecs[1]  = '{"lbu_a2",  mk(32'h1000_0004, 3'b100, 4'b0100, 4'h0, 32'h0000_0102, RF_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 5'd6, 6'd8, 6'd4),
                 32'h80FF_7F00, 1'b1, 1'b1, 1'b1, 32'h0000_00FF};
    vecs[2]  = '{"lh_a0",   mk(32'h1000_0008, 3'b001, 4'b0011, 4'h0, 32'h0000_0200, RF_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 5'd7, 6'd9, 6'd10),
                 32'h1234_8001, 1'b1, 1'b1, 1'b1, 32'hFFFF_8001};
    vecs[3]  = '{"lhu_a2",  mk(32'h1000_000C, 3'b101, 4'b1100, 4'h0, 32'h0000_0202, RF_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 5'd8, 6'd11, 6'd13),
                 32'hBEEF_0000, 1'b1, 1'b1, 1'b1, 32'h0000_BEEF};
    vecs[4]  = '{"lw_a0",   mk(32'h1000_0010, 3'b010, 4'b1111, 4'h0, 32'h0000_0300, RF_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 5'd9, 6'd14, 6'd15),
                 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF};
    vecs[5]  = '{"addi_x0", mk(32'h1000_0014, 3'b000, 4'h0, 4'h0, 32'h0, RF_ALU, 32'h0000_0055, 1'b0, 32'h0, 1'b1, 5'd0, 6'd16, 6'd17),
                 32'h0, 1'b0, 1'b1, 1'b0, 32'h0};
    vecs[6]  = '{"jal",     mk(32'h6000_0010, 3'b000, 4'h0, 4'h0, 32'h0, RF_PC4, 32'h0, 1'b0, 32'h0, 1'b1, 5'd1, 6'd12, 6'd5),
                 32'h0, 1'b0, 1'b1, 1'b1, 32'h6000_0014};
    vecs[7]  = '{"sltu",    mk(32'h1000_001C, 3'b011, 4'h0, 4'h0, 32'h0, RF_BR, 32'h0, 1'b1, 32'h0, 1'b1, 5'd10, 6'd18, 6'd19),
                 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0001};
    vecs[8]  = '{"lui",     mk(32'h1000_0020, 3'b000, 4'h0, 4'h0, 32'h0, RF_UIMM, 32'h0, 1'b0, 32'hABCD_E000, 1'b1, 5'd11, 6'd20, 6'd21),
                 32'h0, 1'b0, 1'b1, 1'b1, 32'hABCD_E000};
    vecs[9]  = '{"sw",      mk(32'h1000_0024, 3'b010, 4'h0, 4'hF, 32'h0000_0400, RF_ALU, 32'h0, 1'b0, 32'h0, 1'b0, 5'd12, 6'd22, 6'd23),
                 32'h0, 1'b1, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{"bubble",  mk(32'h1000_0028, 3'b010, 4'hF, 4'h0, 32'h0, RF_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 5'd13, 6'd24, 6'd25),
                 32'h1111_1111, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10].mw.valid = 1'b0;
    vecs[11] = '{"lb_a3",   mk(32'h1000_002C, 3'b000, 4'b1000, 4'h0, 32'h0000_0503, RF_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 5'd14, 6'd26, 6'd27),
                 32'h7F00_0000, 1'b1, 1'b1, 1'b1, 32'h0000_007F};

    // Reset state
    rst_n      = 1'b0;
    mem_wb_now = '0;
    dmem_rdata = 32'h0;
    dmem_resp  = 1'b0;
    #1;
    chk("reset_commit_valid", {63'h0, commit_valid}, 64'd0);
    chk("reset_rd_we",        {63'h0, rd_we},        64'd0);
    chk("reset_free_valid",   {63'h0, free_valid},   64'd0);
    chk("reset_rd_data",      {32'h0, rd_data},      64'd0);
    chk("reset_commit_order", commit_order,          64'd0);
    chk("reset_proto_err",    {63'h0, proto_err},    64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle commits
    for (int i = 0; i < NV; i++) begin
      mem_wb_now = vecs[i].mw;
      dmem_rdata = vecs[i].rdata;
      dmem_resp  = vecs[i].resp;
      #1;
      chk({vecs[i].name, "_freeze"}, {63'h0, freeze_stall}, 64'd0);
      @(posedge clk);
      #1;
      chk({vecs[i].name, "_commit_valid"}, {63'h0, commit_valid}, {63'h0, vecs[i].e_commit});
      chk({vecs[i].name, "_rd_we"},        {63'h0, rd_we},        {63'h0, vecs[i].e_we});
      chk({vecs[i].name, "_free_valid"},   {63'h0, free_valid},   {63'h0, vecs[i].e_we});
      if (vecs[i].e_we) begin
        chk({vecs[i].name, "_rd_data"},   {32'h0, rd_data},   {32'h0, vecs[i].e_data});
        chk({vecs[i].name, "_rd_phys"},   {58'h0, rd_phys},   {58'h0, vecs[i].mw.dest_phys_new});
        chk({vecs[i].name, "_free_phys"}, {58'h0, free_phys}, {58'h0, vecs[i].mw.dest_phys_old});
      end
      if (vecs[i].e_commit) begin
        chk({vecs[i].name, "_commit_order"}, commit_order, exp_order);
        chk({vecs[i].name, "_commit_arch"},  {59'h0, commit_arch}, {59'h0, vecs[i].mw.dest_arch});
        chk({vecs[i].name, "_commit_pc"},    {32'h0, commit_pc},   {32'h0, vecs[i].mw.pc});
        exp_order++;
      end
      @(negedge clk);
    end
    chk("table_proto_err", {63'h0, proto_err}, 64'd0);

    // lw with 3 wait cycles; rdata is junk until the response cycle
    begin
      int stalls;
      stalls = 0;
      mem_wb_now = mk(32'h2000_0000, 3'b010, 4'hF, 4'h0, 32'h0000_0100, RF_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 5'd3, 6'd30, 6'd31);
      dmem_resp  = 1'b0;
      for (int w = 0; w < 3; w++) begin
        dmem_rdata = $urandom;
        #1;
        if (freeze_stall) stalls++;
        @(posedge clk);
        #1;
        chk("wait_no_commit", {63'h0, commit_valid}, 64'd0);
        @(negedge clk);
      end
      dmem_resp  = 1'b1;
      dmem_rdata = 32'h1357_9BDF;
      #1;
      chk("wait_resp_freeze", {63'h0, freeze_stall}, 64'd0);
      chk("wait_stall_cycles", 64'(stalls), 64'd3);
      @(posedge clk);
      #1;
      chk("wait_rd_we",        {63'h0, rd_we},   64'd1);
      chk("wait_rd_data",      {32'h0, rd_data}, 64'h1357_9BDF);
      chk("wait_commit_order", commit_order,     exp_order);
      exp_order++;
      @(negedge clk);
      mem_wb_now = '0;
      dmem_resp  = 1'b0;
      @(posedge clk);
      #1;
      chk("wait_single_pulse", {63'h0, commit_valid}, 64'd0);
    end

    // Stray response with no memory op sets a sticky error
    @(negedge clk);
    dmem_resp = 1'b1;
    @(posedge clk);
    #1;
    chk("stray_proto_err",  {63'h0, proto_err},    64'd1);
    chk("stray_no_commit",  {63'h0, commit_valid}, 64'd0);
    @(negedge clk);
    dmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stray_sticky", {63'h0, proto_err}, 64'd1);

    // Reset asserted while waiting on memory
    @(negedge clk);
    mem_wb_now = mk(32'h3000_0000, 3'b010, 4'hF, 4'h0, 32'h0, RF_LOAD, 32'h0, 1'b0, 32'h0, 1'b1, 5'd4, 6'd33, 6'd34);
    dmem_resp  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_wait_commit_valid", {63'h0, commit_valid}, 64'd0);
    chk("rst_wait_rd_we",        {63'h0, rd_we},        64'd0);
    chk("rst_wait_proto_err",    {63'h0, proto_err},    64'd0);
    chk("rst_wait_commit_order", commit_order,          64'd0);
    mem_wb_now = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_order = 64'd0;
    mem_wb_now = mk(32'h3000_0100, 3'b000, 4'h0, 4'h0, 32'h0, RF_ALU, 32'h0000_0077, 1'b0, 32'h0, 1'b1, 5'd2, 6'd35, 6'd36);
    @(posedge clk);
    #1;
    chk("post_rst_commit_valid", {63'h0, commit_valid}, 64'd1);
    chk("post_rst_commit_order", commit_order,          exp_order);
    chk("post_rst_rd_data",      {32'h0, rd_data},      64'h77);
    @(negedge clk);
    mem_wb_now = '0;
    @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
